// File: rtl/rggen_axi4lite_responder.sv
// rggen_axi4lite_responder
//   AXI4-Lite subordinate front end for an rggen register bus. AW, W and AR
//   each land in a one-entry buffer. A single FSM issues one register-bus
//   request at a time and returns the B or R response.
// Ports
//   i_clk, i_rst           : clock, synchronous active-high reset
//   AXI AW/W/B/AR/R        : AXI4-Lite subordinate channels (prot ignored)
//   o_bus_*                : register-bus request (valid/access/address/data/strobe)
//   i_bus_ready/status/... : register-bus completion, status and read data
module rggen_axi4lite_responder #(
  parameter int ID_WIDTH        = 0,
  parameter int ADDRESS_WIDTH   = 8,
  parameter int BUS_WIDTH       = 32,
  parameter int ACTUAL_ID_WIDTH = (ID_WIDTH > 0) ? ID_WIDTH : 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_awvalid,
  output logic                       o_awready,
  input  logic [ACTUAL_ID_WIDTH-1:0] i_awid,
  input  logic [ADDRESS_WIDTH-1:0]   i_awaddr,
  input  logic [2:0]                 i_awprot,
  input  logic                       i_wvalid,
  output logic                       o_wready,
  input  logic [BUS_WIDTH-1:0]       i_wdata,
  input  logic [BUS_WIDTH/8-1:0]     i_wstrb,
  output logic                       o_bvalid,
  input  logic                       i_bready,
  output logic [ACTUAL_ID_WIDTH-1:0] o_bid,
  output logic [1:0]                 o_bresp,
  input  logic                       i_arvalid,
  output logic                       o_arready,
  input  logic [ACTUAL_ID_WIDTH-1:0] i_arid,
  input  logic [ADDRESS_WIDTH-1:0]   i_araddr,
  input  logic [2:0]                 i_arprot,
  output logic                       o_rvalid,
  input  logic                       i_rready,
  output logic [ACTUAL_ID_WIDTH-1:0] o_rid,
  output logic [1:0]                 o_rresp,
  output logic [BUS_WIDTH-1:0]       o_rdata,
  output logic                       o_bus_valid,
  output logic [1:0]                 o_bus_access,
  output logic [ADDRESS_WIDTH-1:0]   o_bus_address,
  output logic [BUS_WIDTH-1:0]       o_bus_write_data,
  output logic [BUS_WIDTH/8-1:0]     o_bus_strobe,
  input  logic                       i_bus_ready,
  input  logic [1:0]                 i_bus_status,
  input  logic [BUS_WIDTH-1:0]       i_bus_read_data
);

  // state   | meaning
  // IDLE    | waiting for an eligible write (AW+W) or read (AR)
  // BUS_WR  | write request on the register bus, waiting for ready
  // BUS_RD  | read request on the register bus, waiting for ready
  // WR_RESP | B channel valid, waiting for bready
  // RD_RESP | R channel valid, waiting for rready
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BUS_WR  = 3'd1,
    BUS_RD  = 3'd2,
    WR_RESP = 3'd3,
    RD_RESP = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic                       aw_full_q, w_full_q, ar_full_q;
  logic [ACTUAL_ID_WIDTH-1:0] aw_id_q, ar_id_q;
  logic [ADDRESS_WIDTH-1:0]   aw_addr_q, ar_addr_q;
  logic [BUS_WIDTH-1:0]       w_data_q;
  logic [BUS_WIDTH/8-1:0]     w_strb_q;
  logic [1:0]                 status_q;
  logic [BUS_WIDTH-1:0]       rdata_q;
  logic                       last_write_q, last_write_d;

  logic aw_take, w_take, ar_take;
  logic b_done, r_done;
  logic wr_eligible, rd_eligible;
  logic unused_prot;

  assign unused_prot = ^{i_awprot, i_arprot};

  assign o_awready = !aw_full_q;
  assign o_wready  = !w_full_q;
  assign o_arready = !ar_full_q;

  assign aw_take = i_awvalid && !aw_full_q;
  assign w_take  = i_wvalid && !w_full_q;
  assign ar_take = i_arvalid && !ar_full_q;
  assign b_done  = (state_q == WR_RESP) && i_bready;
  assign r_done  = (state_q == RD_RESP) && i_rready;

  assign wr_eligible = aw_full_q && w_full_q;
  assign rd_eligible = ar_full_q;

  // Buffers only clear on their response handshake, so a full buffer can
  // never be refilled in the same cycle it drains.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      ar_full_q <= 1'b0;
      aw_id_q   <= '0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      ar_id_q   <= '0;
      ar_addr_q <= '0;
    end else begin
      if (aw_take) begin
        aw_full_q <= 1'b1;
        aw_id_q   <= (ID_WIDTH > 0) ? i_awid : '0;
        aw_addr_q <= i_awaddr;
      end else if (b_done) begin
        aw_full_q <= 1'b0;
      end
      if (w_take) begin
        w_full_q <= 1'b1;
        w_data_q <= i_wdata;
        w_strb_q <= i_wstrb;
      end else if (b_done) begin
        w_full_q <= 1'b0;
      end
      if (ar_take) begin
        ar_full_q <= 1'b1;
        ar_id_q   <= (ID_WIDTH > 0) ? i_arid : '0;
        ar_addr_q <= i_araddr;
      end else if (r_done) begin
        ar_full_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      last_write_q <= 1'b0;
      status_q     <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_write_q <= last_write_d;
      if ((state_q == BUS_WR || state_q == BUS_RD) && i_bus_ready) begin
        status_q <= i_bus_status;
      end
      if (state_q == BUS_RD && i_bus_ready) begin
        rdata_q <= i_bus_read_data;
      end
    end
  end

  // last_write only moves when a tie is arbitrated, so alternation holds
  // across consecutive contended rounds even if uncontended grants intervene.
  always_comb begin
    state_d      = state_q;
    last_write_d = last_write_q;
    case (state_q)
      IDLE: begin
        if (wr_eligible && rd_eligible) begin
          if (last_write_q) begin
            state_d      = BUS_RD;
            last_write_d = 1'b0;
          end else begin
            state_d      = BUS_WR;
            last_write_d = 1'b1;
          end
        end else if (wr_eligible) begin
          state_d = BUS_WR;
        end else if (rd_eligible) begin
          state_d = BUS_RD;
        end
      end
      BUS_WR:  if (i_bus_ready) state_d = WR_RESP;
      BUS_RD:  if (i_bus_ready) state_d = RD_RESP;
      WR_RESP: if (i_bready)    state_d = IDLE;
      RD_RESP: if (i_rready)    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_bus_valid      = 1'b0;
    o_bus_access     = 2'b00;
    o_bus_address    = '0;
    o_bus_write_data = '0;
    o_bus_strobe     = '0;
    if (state_q == BUS_WR) begin
      o_bus_valid      = 1'b1;
      o_bus_access     = 2'b11;
      o_bus_address    = aw_addr_q;
      o_bus_write_data = w_data_q;
      o_bus_strobe     = w_strb_q;
    end else if (state_q == BUS_RD) begin
      o_bus_valid   = 1'b1;
      o_bus_access  = 2'b10;
      o_bus_address = ar_addr_q;
    end
  end

  assign o_bvalid = (state_q == WR_RESP);
  assign o_bid    = aw_id_q;
  assign o_bresp  = status_q;
  assign o_rvalid = (state_q == RD_RESP);
  assign o_rid    = ar_id_q;
  assign o_rresp  = status_q;
  assign o_rdata  = rdata_q;

endmodule

// File: tb/tb_rggen_axi4lite_responder.sv
module tb_rggen_axi4lite_responder;

  localparam int IDW = 4;
  localparam int AW  = 8;
  localparam int BW  = 32;

  logic            i_clk = 1'b0;
  logic            i_rst;
  logic            i_awvalid, o_awready;
  logic [IDW-1:0]  i_awid;
  logic [AW-1:0]   i_awaddr;
  logic [2:0]      i_awprot;
  logic            i_wvalid, o_wready;
  logic [BW-1:0]   i_wdata;
  logic [BW/8-1:0] i_wstrb;
  logic            o_bvalid, i_bready;
  logic [IDW-1:0]  o_bid;
  logic [1:0]      o_bresp;
  logic            i_arvalid, o_arready;
  logic [IDW-1:0]  i_arid;
  logic [AW-1:0]   i_araddr;
  logic [2:0]      i_arprot;
  logic            o_rvalid, i_rready;
  logic [IDW-1:0]  o_rid;
  logic [1:0]      o_rresp;
  logic [BW-1:0]   o_rdata;
  logic            o_bus_valid;
  logic [1:0]      o_bus_access;
  logic [AW-1:0]   o_bus_address;
  logic [BW-1:0]   o_bus_write_data;
  logic [BW/8-1:0] o_bus_strobe;
  logic            i_bus_ready;
  logic [1:0]      i_bus_status;
  logic [BW-1:0]   i_bus_read_data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 i_clk = ~i_clk;

  rggen_axi4lite_responder #(
    .ID_WIDTH(IDW), .ADDRESS_WIDTH(AW), .BUS_WIDTH(BW)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_awvalid(i_awvalid), .o_awready(o_awready), .i_awid(i_awid),
    .i_awaddr(i_awaddr), .i_awprot(i_awprot),
    .i_wvalid(i_wvalid), .o_wready(o_wready), .i_wdata(i_wdata), .i_wstrb(i_wstrb),
    .o_bvalid(o_bvalid), .i_bready(i_bready), .o_bid(o_bid), .o_bresp(o_bresp),
    .i_arvalid(i_arvalid), .o_arready(o_arready), .i_arid(i_arid),
    .i_araddr(i_araddr), .i_arprot(i_arprot),
    .o_rvalid(o_rvalid), .i_rready(i_rready), .o_rid(o_rid), .o_rresp(o_rresp),
    .o_rdata(o_rdata),
    .o_bus_valid(o_bus_valid), .o_bus_access(o_bus_access),
    .o_bus_address(o_bus_address), .o_bus_write_data(o_bus_write_data),
    .o_bus_strobe(o_bus_strobe), .i_bus_ready(i_bus_ready),
    .i_bus_status(i_bus_status), .i_bus_read_data(i_bus_read_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    tick();
    tick();
    i_rst = 1'b0;
  endtask

  task automatic drop_valids();
    i_awvalid = 1'b0;
    i_wvalid  = 1'b0;
    i_arvalid = 1'b0;
  endtask

  initial begin
    i_rst = 1'b1;
    i_awvalid = 0; i_awid = 0; i_awaddr = 0; i_awprot = 3'b111;
    i_wvalid = 0; i_wdata = 0; i_wstrb = 0; i_bready = 0;
    i_arvalid = 0; i_arid = 0; i_araddr = 0; i_arprot = 3'b111; i_rready = 0;
    i_bus_ready = 0; i_bus_status = 0; i_bus_read_data = 0;
    do_reset();

    chk("rst_awready", o_awready, 1);
    chk("rst_wready", o_wready, 1);
    chk("rst_arready", o_arready, 1);
    chk("rst_bus_valid", o_bus_valid, 0);
    chk("rst_bvalid", o_bvalid, 0);
    chk("rst_rvalid", o_rvalid, 0);
    chk("rst_rdata", o_rdata, 0);
    chk("rst_bid", o_bid, 0);

    // 1: AW+W same cycle, bus ready after two cycles of valid
    i_awvalid = 1; i_awaddr = 8'h10; i_awid = 4'h0;
    i_wvalid = 1; i_wdata = 32'hDEADBEEF; i_wstrb = 4'hF;
    tick();
    drop_valids();
    chk("t1_awready_low", o_awready, 0);
    chk("t1_wready_low", o_wready, 0);
    chk("t1_no_bus_yet", o_bus_valid, 0);
    tick();
    chk("t1_bus_valid", o_bus_valid, 1);
    chk("t1_access", o_bus_access, 2'b11);
    chk("t1_addr", o_bus_address, 8'h10);
    chk("t1_wdata", o_bus_write_data, 32'hDEADBEEF);
    chk("t1_strobe", o_bus_strobe, 4'hF);
    tick();
    chk("t1_bus_valid_2", o_bus_valid, 1);
    chk("t1_addr_2", o_bus_address, 8'h10);
    i_bus_ready = 1; i_bus_status = 2'b00;
    tick();
    i_bus_ready = 0;
    chk("t1_bus_released", o_bus_valid, 0);
    chk("t1_bvalid", o_bvalid, 1);
    chk("t1_bresp", o_bresp, 0);
    chk("t1_bid", o_bid, 0);
    i_bready = 1;
    tick();
    i_bready = 0;
    chk("t1_bvalid_done", o_bvalid, 0);
    chk("t1_awready_back", o_awready, 1);
    chk("t1_wready_back", o_wready, 1);

    // 2: W two cycles before AW, bready held low three cycles
    i_wvalid = 1; i_wdata = 32'hA5A50001; i_wstrb = 4'h3;
    tick();
    drop_valids();
    chk("t2_wready_low", o_wready, 0);
    chk("t2_no_bus_w_only", o_bus_valid, 0);
    tick();
    chk("t2_no_bus_w_only_2", o_bus_valid, 0);
    i_awvalid = 1; i_awaddr = 8'h20; i_awid = 4'h3;
    tick();
    drop_valids();
    chk("t2_no_bus_at_aw", o_bus_valid, 0);
    tick();
    chk("t2_bus_valid", o_bus_valid, 1);
    chk("t2_addr", o_bus_address, 8'h20);
    chk("t2_strobe", o_bus_strobe, 4'h3);
    chk("t2_wdata", o_bus_write_data, 32'hA5A50001);
    i_bus_ready = 1; i_bus_status = 2'b01;
    tick();
    i_bus_ready = 0;
    chk("t2_bvalid_c1", o_bvalid, 1);
    chk("t2_bresp", o_bresp, 2'b01);
    chk("t2_bid", o_bid, 4'h3);
    tick();
    chk("t2_bvalid_c2", o_bvalid, 1);
    tick();
    chk("t2_bvalid_c3", o_bvalid, 1);
    chk("t2_wready_held", o_wready, 0);
    i_bready = 1;
    tick();
    i_bready = 0;
    chk("t2_bvalid_done", o_bvalid, 0);
    chk("t2_wready_back", o_wready, 1);

    // 3: read with SLVERR
    i_arvalid = 1; i_araddr = 8'h24; i_arid = 4'hA;
    tick();
    drop_valids();
    chk("t3_arready_low", o_arready, 0);
    tick();
    chk("t3_bus_valid", o_bus_valid, 1);
    chk("t3_access", o_bus_access, 2'b10);
    chk("t3_addr", o_bus_address, 8'h24);
    chk("t3_strobe", o_bus_strobe, 0);
    chk("t3_wdata_zero", o_bus_write_data, 0);
    i_bus_ready = 1; i_bus_status = 2'b10; i_bus_read_data = 32'h12345678;
    tick();
    i_bus_ready = 0; i_bus_read_data = 0;
    chk("t3_rvalid", o_rvalid, 1);
    chk("t3_rdata", o_rdata, 32'h12345678);
    chk("t3_rresp", o_rresp, 2'b10);
    chk("t3_rid", o_rid, 4'hA);
    i_rready = 1;
    tick();
    i_rready = 0;
    chk("t3_rvalid_done", o_rvalid, 0);
    chk("t3_arready_back", o_arready, 1);

    // 4/5: tie after reset -> write first; second tie -> read first; IDs echoed
    do_reset();
    i_awvalid = 1; i_awaddr = 8'h30; i_awid = 4'h5;
    i_wvalid = 1; i_wdata = 32'h00000055; i_wstrb = 4'hF;
    i_arvalid = 1; i_araddr = 8'h34; i_arid = 4'hA;
    tick();
    drop_valids();
    tick();
    chk("t4_first_access", o_bus_access, 2'b11);
    chk("t4_first_addr", o_bus_address, 8'h30);
    i_bus_ready = 1; i_bus_status = 2'b00;
    tick();
    i_bus_ready = 0;
    chk("t5_bid", o_bid, 4'h5);
    chk("t4_arready_waiting", o_arready, 0);
    i_bready = 1;
    tick();
    i_bready = 0;
    chk("t4_gap", o_bus_valid, 0);
    tick();
    chk("t4_second_access", o_bus_access, 2'b10);
    chk("t4_second_addr", o_bus_address, 8'h34);
    i_bus_ready = 1; i_bus_read_data = 32'h0000CAFE;
    tick();
    i_bus_ready = 0;
    chk("t5_rid", o_rid, 4'hA);
    chk("t4_rdata", o_rdata, 32'h0000CAFE);
    i_rready = 1;
    tick();
    i_rready = 0;
    i_awvalid = 1; i_awaddr = 8'h3C; i_awid = 4'h6;
    i_wvalid = 1; i_wdata = 32'h00000077; i_wstrb = 4'h1;
    i_arvalid = 1; i_araddr = 8'h38; i_arid = 4'h9;
    tick();
    drop_valids();
    tick();
    chk("t4_tie2_access", o_bus_access, 2'b10);
    chk("t4_tie2_addr", o_bus_address, 8'h38);
    i_bus_ready = 1; i_bus_read_data = 32'h0BADF00D;
    tick();
    i_bus_ready = 0;
    chk("t4_tie2_rid", o_rid, 4'h9);
    i_rready = 1;
    tick();
    i_rready = 0;
    tick();
    chk("t4_tie2_then_write", o_bus_access, 2'b11);
    chk("t4_tie2_waddr", o_bus_address, 8'h3C);
    i_bus_ready = 1;
    tick();
    i_bus_ready = 0;
    chk("t4_tie2_bid", o_bid, 4'h6);
    i_bready = 1;
    tick();
    i_bready = 0;

    // 6: reset while a read is on the bus
    i_arvalid = 1; i_araddr = 8'h40; i_arid = 4'h2;
    tick();
    drop_valids();
    tick();
    chk("t6_bus_rd", o_bus_valid, 1);
    i_rst = 1;
    tick();
    i_rst = 0;
    chk("t6_bus_valid_cleared", o_bus_valid, 0);
    chk("t6_awready", o_awready, 1);
    chk("t6_wready", o_wready, 1);
    chk("t6_arready", o_arready, 1);
    chk("t6_rid_cleared", o_rid, 0);
    i_bus_ready = 1; i_bus_read_data = 32'hFFFFFFFF;
    tick();
    i_bus_ready = 0;
    chk("t6_stray_ready_rvalid", o_rvalid, 0);
    chk("t6_stray_ready_bus", o_bus_valid, 0);
    tick();
    chk("t6_no_rvalid_later", o_rvalid, 0);
    chk("t6_rdata_cleared", o_rdata, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
